// File: rtl/vga_pkg.sv
// box_raster shared types and defaults.
// Timing geometry, colours and the box record used by the raster.
package vga_pkg;

  typedef logic [11:0] rgb_t;

  localparam int PIX_DIV_D  = 4;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam rgb_t COL_BG_D  = 12'h000;
  localparam rgb_t COL_A_D   = 12'hF00;
  localparam rgb_t COL_B_D   = 12'h0F0;
  localparam rgb_t COL_HIT_D = 12'hFF0;

  typedef struct packed {
    logic [11:0] x1;
    logic [11:0] x2;
    logic [11:0] y1;
    logic [11:0] y2;
  } box_t;

  // Half-open inside test; an inverted box is empty.
  function automatic logic box_in(
    box_t b,
    logic [11:0] h,
    logic [11:0] v
  );
    return (h >= b.x1) && (h < b.x2) &&
           (v >= b.y1) && (v < b.y2);
  endfunction

endpackage

// File: rtl/box_raster_if.sv
// box_raster bus: box coordinates in, VGA stream out.
// master drives boxes, slave is the raster.
interface box_raster_if;
  import vga_pkg::*;

  logic [11:0] i_a_x1;
  logic [11:0] i_a_x2;
  logic [11:0] i_a_y1;
  logic [11:0] i_a_y2;
  logic [11:0] i_b_x1;
  logic [11:0] i_b_x2;
  logic [11:0] i_b_y1;
  logic [11:0] i_b_y2;

  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [9:0]  o_x;
  logic [9:0]  o_y;
  rgb_t        o_rgb;
  logic        o_ani_stb;
  logic        o_hit;

  modport master (
    output i_a_x1, i_a_x2, i_a_y1, i_a_y2,
    output i_b_x1, i_b_x2, i_b_y1, i_b_y2,
    input  o_hs, o_vs, o_de, o_x, o_y,
    input  o_rgb, o_ani_stb, o_hit
  );

  modport slave (
    input  i_a_x1, i_a_x2, i_a_y1, i_a_y2,
    input  i_b_x1, i_b_x2, i_b_y1, i_b_y2,
    output o_hs, o_vs, o_de, o_x, o_y,
    output o_rgb, o_ani_stb, o_hit
  );

endinterface

// File: rtl/raster_timing.sv
// Pixel-strobe divider and h/v raster counters.
// Sync/visible windows are decoded from the live counters.
module raster_timing #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_pix_stb,
  output logic [11:0] o_h,
  output logic [11:0] o_v,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame_stb,
  output logic        o_last_stb
);

  localparam int DW = $clog2(PIX_DIV);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC;

  logic [DW-1:0] div;
  logic          h_end;
  logic          v_end;

  assign o_pix_stb = (div == DW'(PIX_DIV - 1));
  assign h_end = (o_h == 12'(H_TOTAL - 1));
  assign v_end = (o_v == 12'(V_TOTAL - 1));

  // Divider wraps on the strobe; counters step once per pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div <= '0;
      o_h <= '0;
      o_v <= '0;
    end else begin
      div <= o_pix_stb ? '0 : div + DW'(1);
      if (o_pix_stb) begin
        if (h_end) begin
          o_h <= '0;
          o_v <= v_end ? 12'd0 : o_v + 12'd1;
        end else begin
          o_h <= o_h + 12'd1;
        end
      end
    end
  end

  assign o_hs = !((o_h >= 12'(HS_LO)) &&
                  (o_h < 12'(HS_HI)));
  assign o_vs = !((o_v >= 12'(VS_LO)) &&
                  (o_v < 12'(VS_HI)));
  assign o_de = (o_h < 12'(H_ACTIVE)) &&
                (o_v < 12'(V_ACTIVE));

  assign o_frame_stb = o_pix_stb &&
    (o_h == 12'(H_ACTIVE - 1)) &&
    (o_v == 12'(V_ACTIVE - 1));
  assign o_last_stb = o_pix_stb && h_end && v_end;

endmodule

// File: rtl/box_raster.sv
// Two-box compositor on a VGA raster.
// Shadowed boxes, colour mux, per-frame collision flag.
module box_raster
  import vga_pkg::*;
#(
  parameter int   PIX_DIV  = PIX_DIV_D,
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter rgb_t COL_BG   = COL_BG_D,
  parameter rgb_t COL_A    = COL_A_D,
  parameter rgb_t COL_B    = COL_B_D,
  parameter rgb_t COL_HIT  = COL_HIT_D
) (
  input  logic  i_clk,
  input  logic  i_rst,
  box_raster_if.slave bus
);

  logic        pix_stb;
  logic        frame_stb;
  logic        last_stb;
  logic [11:0] h;
  logic [11:0] v;
  logic        t_hs;
  logic        t_vs;
  logic        t_de;

  box_t in_a;
  box_t in_b;
  box_t sh_a;
  box_t sh_b;
  logic a_in;
  logic b_in;
  logic hit_now;
  logic hit_acc;
  rgb_t col;

  logic       hs_q;
  logic       vs_q;
  logic       de_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  rgb_t       rgb_q;
  logic       hit_q;

  raster_timing #(
    .PIX_DIV  (PIX_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_pix_stb   (pix_stb),
    .o_h         (h),
    .o_v         (v),
    .o_hs        (t_hs),
    .o_vs        (t_vs),
    .o_de        (t_de),
    .o_frame_stb (frame_stb),
    .o_last_stb  (last_stb)
  );

  assign in_a = '{x1: bus.i_a_x1, x2: bus.i_a_x2,
                  y1: bus.i_a_y1, y2: bus.i_a_y2};
  assign in_b = '{x1: bus.i_b_x1, x2: bus.i_b_x2,
                  y1: bus.i_b_y1, y2: bus.i_b_y2};

  // Boxes only change at the very last pixel, so no tearing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_a <= '0;
      sh_b <= '0;
    end else if (last_stb) begin
      sh_a <= in_a;
      sh_b <= in_b;
    end
  end

  assign a_in = box_in(sh_a, h, v);
  assign b_in = box_in(sh_b, h, v);
  assign hit_now = t_de && a_in && b_in;

  // Colour priority: blank, overlap, A, B, background.
  always_comb begin
    col = COL_BG;
    priority case (1'b1)
      !t_de:        col = '0;
      a_in && b_in: col = COL_HIT;
      a_in:         col = COL_A;
      b_in:         col = COL_B;
      default:      col = COL_BG;
    endcase
  end

  // Overlap accumulates over the frame, reported at frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_acc <= 1'b0;
      hit_q   <= 1'b0;
    end else if (frame_stb) begin
      hit_q   <= hit_acc | hit_now;
      hit_acc <= 1'b0;
    end else if (pix_stb && hit_now) begin
      hit_acc <= 1'b1;
    end
  end

  // Output stage, one pixel behind the counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
    end else if (pix_stb) begin
      hs_q  <= t_hs;
      vs_q  <= t_vs;
      de_q  <= t_de;
      x_q   <= h[9:0];
      y_q   <= v[9:0];
      rgb_q <= col;
    end
  end

  assign bus.o_hs      = hs_q;
  assign bus.o_vs      = vs_q;
  assign bus.o_de      = de_q;
  assign bus.o_x       = x_q;
  assign bus.o_y       = y_q;
  assign bus.o_rgb     = rgb_q;
  assign bus.o_ani_stb = frame_stb;
  assign bus.o_hit     = hit_q;

endmodule

// File: tb/tb_box_raster.sv
// box_raster bench on a shrunken raster.
// Model derives every output from cycles since reset.
module tb_box_raster;

  localparam int D   = 2;
  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 30;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FR  = HT * VT;
  localparam int ANI = (VA - 1) * HT + HA - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  box_raster_if bus ();

  box_raster #(
    .PIX_DIV  (D),
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .COL_BG   (12'h000),
    .COL_A    (12'hF00),
    .COL_B    (12'h0F0),
    .COL_HIT  (12'hFF0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int vec  = 0;
  int errs = 0;
  int t    = 0;

  logic [3:0][11:0] ia = '0;
  logic [3:0][11:0] ib = '0;
  logic [3:0][11:0] sa = '0;
  logic [3:0][11:0] sb = '0;
  logic exp_hit = 1'b0;

  logic        e_hs, e_vs, e_de, e_ani;
  logic [9:0]  e_x, e_y;
  logic [11:0] e_rgb;

  task automatic set_boxes(
    input logic [3:0][11:0] a,
    input logic [3:0][11:0] b
  );
    ia = a;
    ib = b;
    bus.i_a_x1 = a[0];
    bus.i_a_x2 = a[1];
    bus.i_a_y1 = a[2];
    bus.i_a_y2 = a[3];
    bus.i_b_x1 = b[0];
    bus.i_b_x2 = b[1];
    bus.i_b_y1 = b[2];
    bus.i_b_y2 = b[3];
  endtask

  function automatic logic [3:0][11:0] mk(
    int x1, int x2, int y1, int y2
  );
    logic [3:0][11:0] b;
    b[0] = 12'(x1);
    b[1] = 12'(x2);
    b[2] = 12'(y1);
    b[3] = 12'(y2);
    return b;
  endfunction

  function automatic logic [3:0][11:0] rand_box();
    logic [3:0][11:0] b;
    b[0] = 12'($urandom_range(0, 45));
    b[1] = 12'($urandom_range(0, 50));
    b[2] = 12'($urandom_range(0, 34));
    b[3] = 12'($urandom_range(0, 38));
    if ($urandom_range(0, 7) == 0) b[0] = 12'd4090;
    return b;
  endfunction

  function automatic bit inside_box(
    logic [3:0][11:0] b, int h, int v
  );
    return h >= int'(b[0]) && h < int'(b[1]) &&
           v >= int'(b[2]) && v < int'(b[3]);
  endfunction

  // Does the visible rectangle contain any A∩B pixel?
  function automatic bit overlap(
    logic [3:0][11:0] a, logic [3:0][11:0] b
  );
    int lx, rx, ly, ry;
    lx = int'(a[0]) > int'(b[0]) ? int'(a[0]) : int'(b[0]);
    rx = int'(a[1]) < int'(b[1]) ? int'(a[1]) : int'(b[1]);
    ly = int'(a[2]) > int'(b[2]) ? int'(a[2]) : int'(b[2]);
    ry = int'(a[3]) < int'(b[3]) ? int'(a[3]) : int'(b[3]);
    if (rx > HA) rx = HA;
    if (ry > VA) ry = VA;
    return (lx < rx) && (ly < ry);
  endfunction

  // One clock; model the shadow latch and frame-end flag.
  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    if (r) begin
      t = 0;
      sa = '0;
      sb = '0;
      exp_hit = 1'b0;
    end else begin
      if (t % D == D - 1) begin
        if ((t / D) % FR == FR - 1) begin
          sa = ia;
          sb = ib;
        end
        if ((t / D) % FR == ANI) exp_hit = overlap(sa, sb);
      end
      t++;
    end
    #1;
  endtask

  task automatic calc();
    int n, q, h, v;
    bit ina, inb;
    e_ani = (t % D == D - 1) && ((t / D) % FR == ANI);
    if (t < D) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
      e_x = '0; e_y = '0; e_rgb = '0;
    end else begin
      n = t / D - 1;
      q = n % FR;
      h = q % HT;
      v = q / HT;
      e_x = 10'(h);
      e_y = 10'(v);
      e_hs = !(h >= HA + HFP && h < HA + HFP + HSW);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VSW);
      e_de = (h < HA) && (v < VA);
      ina = inside_box(sa, h, v);
      inb = inside_box(sb, h, v);
      if (!e_de) e_rgb = 12'h000;
      else if (ina && inb) e_rgb = 12'hFF0;
      else if (ina) e_rgb = 12'hF00;
      else if (inb) e_rgb = 12'h0F0;
      else e_rgb = 12'h000;
    end
  endtask

  task automatic test_sweep(string tag, int n, bit rnd);
    logic [36:0] got, want;
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 399) == 0)
        set_boxes(rand_box(), rand_box());
      step();
      calc();
      got = {bus.o_hs, bus.o_vs, bus.o_de, bus.o_x,
             bus.o_y, bus.o_rgb, bus.o_ani_stb, bus.o_hit};
      want = {e_hs, e_vs, e_de, e_x, e_y, e_rgb,
              e_ani, exp_hit};
      vec++;
      if (got !== want) begin
        errs++;
        $display("FAIL %s t=%0d got=%h want=%h",
                 tag, t, got, want);
      end
    end
  endtask

  task automatic goto_px(int f, int h, int v);
    int tgt;
    int g;
    tgt = D * (f * FR + v * HT + h + 1);
    g = 0;
    while (t < tgt && g < 4 * D * FR) begin
      step();
      g++;
    end
    vec++;
    if (t != tgt) begin
      errs++;
      $display("FAIL goto t=%0d want=%0d", t, tgt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_boxes('0, '0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vec++;
    if ({bus.o_hs, bus.o_vs, bus.o_de} !== 3'b110) begin
      errs++;
      $display("FAIL reset_sync got=%b want=110",
               {bus.o_hs, bus.o_vs, bus.o_de});
    end
    vec++;
    if ({bus.o_x, bus.o_y} !== 20'd0) begin
      errs++;
      $display("FAIL reset_xy got=%h want=0",
               {bus.o_x, bus.o_y});
    end
    vec++;
    if ({bus.o_rgb, bus.o_ani_stb, bus.o_hit} !== 14'd0) begin
      errs++;
      $display("FAIL reset_rgb got=%h want=0",
               {bus.o_rgb, bus.o_ani_stb, bus.o_hit});
    end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    int g, t0, lows, fx, badv, vlows;
    do_reset();
    g = 0;
    while (bus.o_ani_stb !== 1'b1 && g < 2 * D * FR) begin
      step();
      g++;
    end
    vec++;
    if (t != D * ANI + D - 1) begin
      errs++;
      $display("FAIL first_ani t=%0d want=%0d",
               t, D * ANI + D - 1);
    end
    t0 = t;
    step();
    g = 0;
    while (bus.o_ani_stb !== 1'b1 && g < 2 * D * FR) begin
      step();
      g++;
    end
    vec++;
    if (t - t0 != D * FR) begin
      errs++;
      $display("FAIL ani_period got=%0d want=%0d",
               t - t0, D * FR);
    end
    goto_px(2, 0, 0);
    lows = 0; fx = -1; badv = 0; vlows = 0;
    for (int i = 0; i < D * FR; i++) begin
      if (t % D == 0) begin
        if (bus.o_hs === 1'b0) begin
          if (bus.o_y == 10'd3) lows++;
          if (fx < 0) fx = int'(bus.o_x);
        end
        if (bus.o_vs === 1'b0) begin
          vlows++;
          if (bus.o_y < 10'(VA + VFP) ||
              bus.o_y >= 10'(VA + VFP + VSW)) badv++;
        end
        if (bus.o_de === 1'b1 &&
            (bus.o_x >= 10'(HA) || bus.o_y >= 10'(VA)))
          badv++;
      end
      step();
    end
    vec++;
    if (lows != HSW) begin
      errs++;
      $display("FAIL hs_width got=%0d want=%0d", lows, HSW);
    end
    vec++;
    if (fx != HA + HFP) begin
      errs++;
      $display("FAIL hs_start got=%0d want=%0d", fx, HA + HFP);
    end
    vec++;
    if (vlows != VSW * HT || badv != 0) begin
      errs++;
      $display("FAIL vs_de got=%0d/%0d want=%0d/0",
               vlows, badv, VSW * HT);
    end
  endtask

  task automatic test_background();
    do_reset();
    set_boxes(mk(5, 30, 5, 20), mk(10, 35, 8, 25));
    test_sweep("bg_frame", D * FR + 20, 1'b0);
  endtask

  task automatic test_single_box();
    do_reset();
    set_boxes(mk(10, 20, 10, 20), '0);
    goto_px(0, 10, 10);
    vec++;
    if (bus.o_rgb !== 12'h000) begin
      errs++;
      $display("FAIL box_f1 got=%h want=000", bus.o_rgb);
    end
    goto_px(1, 10, 10);
    vec++;
    if (bus.o_rgb !== 12'hF00) begin
      errs++;
      $display("FAIL box_tl got=%h want=F00", bus.o_rgb);
    end
    goto_px(1, 20, 10);
    vec++;
    if (bus.o_rgb !== 12'h000) begin
      errs++;
      $display("FAIL box_right got=%h want=000", bus.o_rgb);
    end
    goto_px(1, 10, 20);
    vec++;
    if (bus.o_rgb !== 12'h000) begin
      errs++;
      $display("FAIL box_bottom got=%h want=000", bus.o_rgb);
    end
    test_sweep("single", D * HT * 4, 1'b0);
  endtask

  task automatic test_collision();
    do_reset();
    set_boxes(mk(10, 20, 10, 20), mk(15, 25, 15, 25));
    goto_px(1, 17, 17);
    vec++;
    if (bus.o_rgb !== 12'hFF0) begin
      errs++;
      $display("FAIL hit_px got=%h want=FF0", bus.o_rgb);
    end
    goto_px(1, HA - 1, VA - 1);
    vec++;
    if (bus.o_hit !== 1'b1) begin
      errs++;
      $display("FAIL hit_set got=%b want=1", bus.o_hit);
    end
    set_boxes(mk(10, 20, 10, 20), mk(30, 38, 2, 8));
    test_sweep("collide", D * FR, 1'b0);
    vec++;
    if (bus.o_hit !== 1'b0) begin
      errs++;
      $display("FAIL hit_clear got=%b want=0", bus.o_hit);
    end
  endtask

  task automatic test_wrap();
    int drawn;
    do_reset();
    set_boxes('0, mk(4090, 20, 0, 30));
    goto_px(1, 0, 0);
    drawn = 0;
    for (int i = 0; i < D * FR; i++) begin
      step();
      if (bus.o_rgb !== 12'h000) drawn++;
    end
    vec++;
    if (drawn != 0) begin
      errs++;
      $display("FAIL wrap_drawn got=%0d want=0", drawn);
    end
    set_boxes(mk(4090, 20, 3, 9), mk(2, 4000, 4090, 8));
    test_sweep("wrap", D * FR, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    set_boxes(rand_box(), rand_box());
    test_sweep("random", 3 * D * FR, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_boxes(mk(0, 40, 0, 30), mk(0, 40, 0, 30));
    goto_px(1, 17, 20);
    rst = 1'b1;
    step();
    vec++;
    if ({bus.o_hs, bus.o_vs, bus.o_de} !== 3'b110) begin
      errs++;
      $display("FAIL mid_sync got=%b want=110",
               {bus.o_hs, bus.o_vs, bus.o_de});
    end
    vec++;
    if ({bus.o_x, bus.o_y, bus.o_rgb} !== 32'd0) begin
      errs++;
      $display("FAIL mid_px got=%h want=0",
               {bus.o_x, bus.o_y, bus.o_rgb});
    end
    vec++;
    if ({bus.o_ani_stb, bus.o_hit} !== 2'b00) begin
      errs++;
      $display("FAIL mid_stb got=%b want=00",
               {bus.o_ani_stb, bus.o_hit});
    end
    rst = 1'b0;
    test_sweep("after_rst", D * FR + 10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_background();
    test_single_box();
    test_collision();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/box_raster.md
# box_raster

Raster-side consumer of the animated-object bounding boxes. It generates 640x480 VGA timing from `i_clk` via a pixel-strobe divider and produces the once-per-frame animation strobe that drives the box animators. It also composites two rectangles (player A, obstacle B) into 12-bit RGB and reports a per-frame collision flag. It sits between the box animators and the VGA pins.

## Interface

Parameters:
- `PIX_DIV`, 4: `i_clk` cycles per pixel; must be ≥2.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `COL_BG`, 12'h000: background colour.
- `COL_A`, 12'hF00: colour of box A.
- `COL_B`, 12'h0F0: colour of box B.
- `COL_HIT`, 12'hFF0: colour where boxes A and B overlap.

Ports:
- `i_clk` in 1: base clock.
- `i_rst` in 1: reset, synchronous, active-high, sampled on `i_clk`.
- `i_a_x1`, `i_a_x2`, `i_a_y1`, `i_a_y2` in 12 each: box A left, right, top, bottom.
- `i_b_x1`, `i_b_x2`, `i_b_y1`, `i_b_y2` in 12 each: box B left, right, top, bottom.
- `o_hs` out 1: horizontal sync, active-low.
- `o_vs` out 1: vertical sync, active-low.
- `o_de` out 1: high in the visible area.
- `o_x` out 10: pixel column of the current output.
- `o_y` out 10: pixel row of the current output.
- `o_rgb` out 12: pixel colour, {R[3:0], G[3:0], B[3:0]}.
- `o_ani_stb` out 1: one-`i_clk` pulse at the end of the active frame.
- `o_hit` out 1: collision flag for the last completed frame.

## Operation

Pixel strobe:
- A modulo-`PIX_DIV` counter runs on `i_clk`.
- `pix_stb` is high for one `i_clk` cycle when the counter equals `PIX_DIV-1`.

Raster counters:
- `h` counts 0..H_TOTAL-1 and `v` counts 0..V_TOTAL-1, advancing only on `pix_stb`.
- H_TOTAL = 800 and V_TOTAL = 525 at the default parameters.
- `h` wraps to 0 and increments `v`; `v` wraps to 0 after the last line.

Shadow boxes:
- All eight coordinates are latched into shadow registers on the `pix_stb` where (h,v) = (H_TOTAL-1, V_TOTAL-1).
- The rendered frame therefore never tears.

Inside test, per box, all comparisons unsigned on 12 bits:
- A pixel is inside when x1 ≤ h < x2 and y1 ≤ v < y2.
- If x1 ≥ x2 or y1 ≥ y2 (including underflow wrap), the box is empty.

Colour:
- Blanked pixels output 0.
- In A and B: `COL_HIT`.
- In A only: `COL_A`.
- In B only: `COL_B`.
- Otherwise: `COL_BG`.

Collision:
- `hit_acc` is set by any visible pixel that lies in both A and B.
- On the `o_ani_stb` cycle: `o_hit <= hit_acc | hit_now`, and `hit_acc` clears. `hit_now` is the pixel (H_ACTIVE-1, V_ACTIVE-1), which is evaluated on that same strobe.

Sync windows, evaluated on the counter value:
- `o_hs` = 0 when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- `o_vs` = 0 when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.

## Timing

Output registers:
- `o_hs`, `o_vs`, `o_de`, `o_x`, `o_y` and `o_rgb` are registered together on `pix_stb` from the pre-increment (h,v).
- They are mutually aligned, hold for `PIX_DIV` cycles, and lag the counters by one pixel.

Animation strobe:
- `o_ani_stb` pulses on the `pix_stb` at which (h,v) = (H_ACTIVE-1, V_ACTIVE-1).
- Animators update during blanking, well before the shadow latch.

Reset values:
- `o_hs`=1, `o_vs`=1, `o_de`=0, `o_x`=0, `o_y`=0, `o_rgb`=0, `o_ani_stb`=0, `o_hit`=0.
- Divider, `h`, `v` and `hit_acc` are 0; shadow boxes are all zero, i.e. empty.

Reset mid-frame:
- Takes effect on the next edge and aborts the frame.
- The first frame after reset renders background only, since the shadows are empty.
- The first `o_hit` after reset is 0.

First strobe after reset release:
- The first `pix_stb` occurs `PIX_DIV-1` cycles after reset release (cycle 0).

## Structure

- Package `vga_pkg`: timing defaults, derived H_TOTAL/V_TOTAL, colour constants, and a 12-bit RGB typedef.
- Sub-module `raster_timing`: divider, `h`/`v` counters, sync windows, `pix_stb` and frame-end strobe.
- `box_raster` adds the shadows, inside tests, colour mux, collision accumulator and output registers.

## Test plan

- Reset, run with `PIX_DIV`=4:
  - `pix_stb` fires at cycles 4k+3.
  - First `o_ani_stb` at cycle 1,535,359.
  - Thereafter `o_ani_stb` every 1,680,000 cycles.
- Line timing: exactly 96 pixels per line with `o_hs`=0, first at `o_x`=656; `o_vs`=0 on `o_y`=490–491 only; `o_de`=0 whenever x ≥ 640 or y ≥ 480.
- Single box, A = (100,140,100,140), B empty:
  - Frame 1 is all `COL_BG`.
  - Frame 2: (100,100) = 12'hF00; (140,100) and (100,140) = `COL_BG`.
- Collision, A as above and B = (130,170,130,170):
  - Frame 2: (135,135) = 12'hFF0 and `o_hit`=1 at the next `o_ani_stb`.
  - Moving B to (300,340,300,340) gives `o_hit`=0 one frame later.
- Wrapped box, x1 = 4090, x2 = 20: no B pixels are drawn.
- Reset at line 200, mid-line: next cycle every output equals its reset value, and the counters restart from (0,0).
